// File: rtl/fetch_sequencer_if.sv
// Bundle of every non-clock signal between the fetch sequencer, the PC register,
// instruction memory, decode and branch resolution.
interface fetch_sequencer_if #(
  parameter int INSTR_W = 16
);
  logic [15:0]        inp_pcAddress;
  logic [15:0]        out_nextInstructionAddress;
  logic               out_ChangeAddress;
  logic               out_imemReq;
  logic [15:0]        out_imemAddr;
  logic               inp_imemAck;
  logic [INSTR_W-1:0] inp_imemData;
  logic [INSTR_W-1:0] out_instr;
  logic [15:0]        out_instrPc;
  logic               out_instrValid;
  logic               inp_decodeReady;
  logic               inp_branchTaken;
  logic [15:0]        inp_branchTarget;

  modport master (
    input  inp_pcAddress, inp_imemAck, inp_imemData, inp_decodeReady,
           inp_branchTaken, inp_branchTarget,
    output out_nextInstructionAddress, out_ChangeAddress, out_imemReq,
           out_imemAddr, out_instr, out_instrPc, out_instrValid
  );

  modport slave (
    output inp_pcAddress, inp_imemAck, inp_imemData, inp_decodeReady,
           inp_branchTaken, inp_branchTarget,
    input  out_nextInstructionAddress, out_ChangeAddress, out_imemReq,
           out_imemAddr, out_instr, out_instrPc, out_instrValid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: steers the PC, fetches over a req/ack handshake
// and buffers {pc, instr} pairs in a 2-entry FIFO for decode.
module fetch_sequencer #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter int          INSTR_W    = 16
) (
  input  logic              inp_clk,
  input  logic              inp_rstn,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, STALL, DROP} state_t;

  state_t             state_reg;
  logic [15:0]        held_addr_reg;
  logic [INSTR_W-1:0] instr_mem_reg [2];
  logic [15:0]        pc_mem_reg    [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;

  logic        req;
  logic        ack;
  logic        redirect;
  logic        push;
  logic        pop;
  logic [1:0]  count_next;
  logic [15:0] target_even;

  assign req         = (state_reg == FETCH) || (state_reg == DROP);
  assign ack         = req && bus.inp_imemAck;
  assign redirect    = bus.inp_branchTaken && (state_reg != BOOT);
  assign pop         = (count_reg != 2'd0) && bus.inp_decodeReady;
  assign push        = (state_reg == FETCH) && ack && !redirect;
  assign count_next  = count_reg + {1'b0, push} - {1'b0, pop};
  assign target_even = bus.inp_branchTarget & 16'hFFFE;

  assign bus.out_imemReq    = req;
  assign bus.out_imemAddr   = (state_reg == DROP) ? held_addr_reg : bus.inp_pcAddress;
  assign bus.out_instrValid = (count_reg != 2'd0);
  assign bus.out_instr      = instr_mem_reg[rd_ptr_reg];
  assign bus.out_instrPc    = pc_mem_reg[rd_ptr_reg];

  // BOOT is also the reset state, so its PC load is gated until reset releases.
  always_comb begin
    bus.out_ChangeAddress          = 1'b0;
    bus.out_nextInstructionAddress = RESET_ADDR;
    if (state_reg == BOOT) begin
      bus.out_ChangeAddress = inp_rstn;
    end else if (redirect) begin
      bus.out_ChangeAddress          = 1'b1;
      bus.out_nextInstructionAddress = target_even;
    end else if ((state_reg == FETCH) && ack) begin
      bus.out_ChangeAddress          = 1'b1;
      bus.out_nextInstructionAddress = bus.inp_pcAddress + 16'd2;
    end
  end

  always_ff @(posedge inp_clk or negedge inp_rstn) begin
    if (!inp_rstn) begin
      state_reg     <= BOOT;
      held_addr_reg <= RESET_ADDR;
    end else begin
      if (state_reg == FETCH) begin
        held_addr_reg <= bus.inp_pcAddress;
      end
      case (state_reg)
        BOOT: state_reg <= FETCH;
        FETCH: begin
          // A redirect without ack leaves a request in flight that must be drained.
          if (redirect)
            state_reg <= ack ? FETCH : DROP;
          else if (push && (count_next == 2'd2) && !pop)
            state_reg <= STALL;
          else
            state_reg <= FETCH;
        end
        STALL: begin
          if (redirect || pop)
            state_reg <= FETCH;
        end
        DROP: begin
          if (ack)
            state_reg <= FETCH;
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

  always_ff @(posedge inp_clk or negedge inp_rstn) begin
    if (!inp_rstn) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (redirect) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)
        rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  // Entry storage keeps stale contents across a flush; validity is tracked by count_reg.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge inp_clk or negedge inp_rstn) begin
        if (!inp_rstn) begin
          instr_mem_reg[gi] <= '0;
          pc_mem_reg[gi]    <= 16'h0000;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          instr_mem_reg[gi] <= bus.inp_imemData;
          pc_mem_reg[gi]    <= bus.inp_pcAddress;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register and an
// instruction memory returning addr ^ 16'hA5A5.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstn;
  logic [15:0] pc;
  logic        zero_wait;
  logic        ack_manual;
  int          checks;
  int          errors;

  fetch_sequencer_if #(.INSTR_W(16)) bus ();

  fetch_sequencer #(.RESET_ADDR(16'h1040), .INSTR_W(16)) dut (
    .inp_clk (clk),
    .inp_rstn(rstn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn)                      pc <= 16'h0000;
    else if (bus.out_ChangeAddress) pc <= bus.out_nextInstructionAddress;
  end

  assign bus.inp_pcAddress = pc;
  assign bus.inp_imemAck   = zero_wait ? bus.out_imemReq : ack_manual;
  assign bus.inp_imemData  = bus.out_imemAddr ^ 16'hA5A5;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rstn = 1'b0;
    bus.inp_branchTaken = 1'b0;
    bus.inp_decodeReady = ready;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    zero_wait = 1'b1; ack_manual = 1'b0; rstn = 1'b0;
    bus.inp_decodeReady = 1'b1; bus.inp_branchTaken = 1'b0; bus.inp_branchTarget = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.out_instrValid, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_instr, bus.out_instrPc}
          !== {1'b0, 1'b0, 1'b0, 16'h1040, 16'h0000, 16'h0000}) begin
        errors++;
        $display("FAIL reset_outputs: got v=%b req=%b chg=%b next=%h instr=%h ipc=%h expected 0/0/0/1040/0000/0000",
                 bus.out_instrValid, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_instr, bus.out_instrPc);
      end
    end
    @(negedge clk); rstn = 1'b1; #1;
    checks++;
    if ({bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemReq} !== {1'b1, 16'h1040, 1'b0}) begin
      errors++;
      $display("FAIL boot_cycle: got chg=%b next=%h req=%b expected 1/1040/0", bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemReq);
    end
    step();
    checks++;
    if ({bus.out_imemReq, bus.out_imemAddr, bus.out_ChangeAddress, bus.out_nextInstructionAddress} !== {1'b1, 16'h1040, 1'b1, 16'h1042}) begin
      errors++;
      $display("FAIL first_fetch: got req=%b addr=%h chg=%b next=%h expected 1/1040/1/1042", bus.out_imemReq, bus.out_imemAddr, bus.out_ChangeAddress, bus.out_nextInstructionAddress);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] exp_pc [3];
    logic [15:0] exp_in [3];
    exp_pc = '{16'h1040, 16'h1042, 16'h1044};
    exp_in = '{16'hB5E5, 16'hB5E7, 16'hB5E1};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.out_instrValid, bus.out_instrPc, bus.out_instr, pc} !== {1'b1, exp_pc[i], exp_in[i], exp_pc[i] + 16'd2}) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b ipc=%h instr=%h pc=%h expected 1/%h/%h/%h", i,
                 bus.out_instrValid, bus.out_instrPc, bus.out_instr, pc, exp_pc[i], exp_in[i], exp_pc[i] + 16'd2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc [3];
    zero_wait = 1'b1;
    do_reset(1'b0);
    step();
    checks++;
    if ({bus.out_instrValid, bus.out_instrPc, pc} !== {1'b1, 16'h1040, 16'h1042}) begin
      errors++;
      $display("FAIL bp_first_push: got v=%b ipc=%h pc=%h expected 1/1040/1042", bus.out_instrValid, bus.out_instrPc, pc);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({bus.out_imemReq, bus.out_ChangeAddress, pc, bus.out_instrPc} !== {1'b0, 1'b0, 16'h1044, 16'h1040}) begin
        errors++;
        $display("FAIL bp_stall_%0d: got req=%b chg=%b pc=%h ipc=%h expected 0/0/1044/1040", i, bus.out_imemReq, bus.out_ChangeAddress, pc, bus.out_instrPc);
      end
    end
    bus.inp_decodeReady = 1'b1;
    #1;
    exp_pc = '{16'h1040, 16'h1042, 16'h1044};
    for (int i = 0; i < 3; i++) begin
      if (i != 0) step();
      checks++;
      if ({bus.out_instrValid, bus.out_instrPc, bus.out_instr} !== {1'b1, exp_pc[i], exp_pc[i] ^ 16'hA5A5}) begin
        errors++;
        $display("FAIL bp_drain_%0d: got v=%b ipc=%h instr=%h expected 1/%h/%h", i, bus.out_instrValid, bus.out_instrPc, bus.out_instr, exp_pc[i], exp_pc[i] ^ 16'hA5A5);
      end
    end
    checks++;
    if ({bus.out_imemReq, bus.out_imemAddr} !== {1'b1, 16'h1046}) begin
      errors++;
      $display("FAIL bp_resume_req: got req=%b addr=%h expected 1/1046", bus.out_imemReq, bus.out_imemAddr);
    end
  endtask

  task automatic test_branch_drop();
    zero_wait = 1'b0; ack_manual = 1'b1;
    do_reset(1'b1);
    step();
    ack_manual = 1'b0;
    bus.inp_branchTaken = 1'b1; bus.inp_branchTarget = 16'h2001;
    #1;
    checks++;
    if ({bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemAddr} !== {1'b1, 16'h2000, 16'h1042}) begin
      errors++;
      $display("FAIL drop_redirect: got chg=%b next=%h addr=%h expected 1/2000/1042", bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemAddr);
    end
    step();
    bus.inp_branchTaken = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) step();
      if (i == 2) begin step(); ack_manual = 1'b1; #1; end
      checks++;
      if ({bus.out_imemReq, bus.out_imemAddr, pc, bus.out_instrValid, bus.out_ChangeAddress} !== {1'b1, 16'h1042, 16'h2000, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL drop_hold_%0d: got req=%b addr=%h pc=%h v=%b chg=%b expected 1/1042/2000/0/0", i,
                 bus.out_imemReq, bus.out_imemAddr, pc, bus.out_instrValid, bus.out_ChangeAddress);
      end
    end
    step();
    checks++;
    if ({bus.out_instrValid, bus.out_imemReq, bus.out_imemAddr} !== {1'b0, 1'b1, 16'h2000}) begin
      errors++;
      $display("FAIL drop_discard: got v=%b req=%b addr=%h expected 0/1/2000", bus.out_instrValid, bus.out_imemReq, bus.out_imemAddr);
    end
    step();
    checks++;
    if ({bus.out_instrValid, bus.out_instrPc, bus.out_instr} !== {1'b1, 16'h2000, 16'h85A5}) begin
      errors++;
      $display("FAIL drop_refetch: got v=%b ipc=%h instr=%h expected 1/2000/85A5", bus.out_instrValid, bus.out_instrPc, bus.out_instr);
    end
  endtask

  task automatic test_back_to_back();
    zero_wait = 1'b1;
    do_reset(1'b1);
    step();
    bus.inp_branchTaken = 1'b1; bus.inp_branchTarget = 16'h3000;
    #1;
    checks++;
    if ({bus.out_instrValid, bus.out_instrPc, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress} !== {1'b1, 16'h1040, 1'b1, 1'b1, 16'h3000}) begin
      errors++;
      $display("FAIL b2b_redirect: got v=%b ipc=%h req=%b chg=%b next=%h expected 1/1040/1/1/3000",
               bus.out_instrValid, bus.out_instrPc, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress);
    end
    step();
    bus.inp_branchTaken = 1'b0;
    #1;
    checks++;
    if ({bus.out_instrValid, pc, bus.out_imemAddr} !== {1'b0, 16'h3000, 16'h3000}) begin
      errors++;
      $display("FAIL b2b_flushed: got v=%b pc=%h addr=%h expected 0/3000/3000", bus.out_instrValid, pc, bus.out_imemAddr);
    end
    step();
    checks++;
    if ({bus.out_instrValid, bus.out_instrPc, bus.out_instr} !== {1'b1, 16'h3000, 16'h95A5}) begin
      errors++;
      $display("FAIL b2b_target: got v=%b ipc=%h instr=%h expected 1/3000/95A5", bus.out_instrValid, bus.out_instrPc, bus.out_instr);
    end
  endtask

  task automatic test_wrap_and_reset();
    bus.inp_branchTaken = 1'b1; bus.inp_branchTarget = 16'hFFFE;
    step();
    bus.inp_branchTaken = 1'b0;
    #1;
    checks++;
    if ({pc, bus.out_imemAddr, bus.out_ChangeAddress, bus.out_nextInstructionAddress} !== {16'hFFFE, 16'hFFFE, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_next: got pc=%h addr=%h chg=%b next=%h expected FFFE/FFFE/1/0000", pc, bus.out_imemAddr, bus.out_ChangeAddress, bus.out_nextInstructionAddress);
    end
    step();
    checks++;
    if ({bus.out_instrPc, bus.out_instr, bus.out_imemAddr} !== {16'hFFFE, 16'h5A5B, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_fetch0: got ipc=%h instr=%h addr=%h expected FFFE/5A5B/0000", bus.out_instrPc, bus.out_instr, bus.out_imemAddr);
    end
    step();
    checks++;
    if ({bus.out_instrValid, bus.out_instrPc, bus.out_instr} !== {1'b1, 16'h0000, 16'hA5A5}) begin
      errors++;
      $display("FAIL wrap_deliver0: got v=%b ipc=%h instr=%h expected 1/0000/A5A5", bus.out_instrValid, bus.out_instrPc, bus.out_instr);
    end
    zero_wait = 1'b0; ack_manual = 1'b0;
    bus.inp_branchTaken = 1'b1; bus.inp_branchTarget = 16'h4000;
    step();
    bus.inp_branchTaken = 1'b0;
    #1;
    checks++;
    if ({bus.out_imemReq, bus.out_imemAddr, pc} !== {1'b1, 16'h0002, 16'h4000}) begin
      errors++;
      $display("FAIL rst_pre_drop: got req=%b addr=%h pc=%h expected 1/0002/4000", bus.out_imemReq, bus.out_imemAddr, pc);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.out_instrValid, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_instr, bus.out_instrPc}
        !== {1'b0, 1'b0, 1'b0, 16'h1040, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL rst_mid_drop: got v=%b req=%b chg=%b next=%h instr=%h ipc=%h expected 0/0/0/1040/0000/0000",
               bus.out_instrValid, bus.out_imemReq, bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_instr, bus.out_instrPc);
    end
    @(negedge clk); rstn = 1'b1; #1;
    checks++;
    if ({bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemReq} !== {1'b1, 16'h1040, 1'b0}) begin
      errors++;
      $display("FAIL rst_reboot: got chg=%b next=%h req=%b expected 1/1040/0", bus.out_ChangeAddress, bus.out_nextInstructionAddress, bus.out_imemReq);
    end
    step();
    checks++;
    if ({bus.out_imemReq, bus.out_imemAddr, bus.out_instrValid} !== {1'b1, 16'h1040, 1'b0}) begin
      errors++;
      $display("FAIL rst_refetch: got req=%b addr=%h v=%b expected 1/1040/0", bus.out_imemReq, bus.out_imemAddr, bus.out_instrValid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_branch_drop();
    test_back_to_back();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch sequencer that sits directly upstream of the PC register and drives its inp_nextInstructionAddress / inp_ChangeAddress inputs. It reads the PC's out_address, fetches from instruction memory with a req/ack handshake, and buffers fetched instructions with their PC in a 2-entry queue for decode. Branch redirects load the PC and flush the queue. Any fetch still outstanding at a redirect is completed and its data discarded.

Parameters:
RESET_ADDR, 16'h0000, address loaded into PC after reset release
INSTR_W, 16, instruction word width

Ports:
inp_clk  in  1  clock, rising edge
inp_rstn  in  1  reset, asynchronous, active-low
inp_pcAddress  in  16  current PC (PC out_address)
out_nextInstructionAddress  out  16  value PC loads when out_ChangeAddress=1
out_ChangeAddress  out  1  PC load enable for this edge
out_imemReq  out  1  fetch request
out_imemAddr  out  16  fetch address
inp_imemAck  in  1  memory response; data valid this cycle
inp_imemData  in  INSTR_W  fetched instruction
out_instr  out  INSTR_W  head-of-queue instruction
out_instrPc  out  16  address of out_instr
out_instrValid  out  1  queue non-empty
inp_decodeReady  in  1  decode consumes head when valid&ready
inp_branchTaken  in  1  redirect, single-cycle
inp_branchTarget  in  16  redirect address

Behaviour:
- Reset (inp_rstn=0, asynchronous): state BOOT, queue empty, out_instrValid=0, out_imemReq=0, out_ChangeAddress=0, out_nextInstructionAddress=RESET_ADDR. out_instr/out_instrPc=0.
- Reset asserted mid-transaction abandons the outstanding fetch. Memory must tolerate this.
- States:
  - BOOT:
    - Holds for exactly 1 cycle after reset release.
    - out_ChangeAddress=1, next=RESET_ADDR.
    - Goes to FETCH. inp_branchTaken is ignored in BOOT.
  - FETCH:
    - out_imemReq=1, out_imemAddr=inp_pcAddress. The address is also captured into heldAddr every cycle.
    - On inp_imemAck:
      - Push {inp_pcAddress, inp_imemData}.
      - out_ChangeAddress=1, next=inp_pcAddress+2, modulo 2^16 (0xFFFE -> 0x0000).
    - After the push, if the queue is full and no pop occurred this cycle -> STALL. Otherwise stay in FETCH.
    - With zero-wait memory (ack in the same cycle as the request), sustained throughput is 1 instruction/cycle.
  - STALL:
    - out_imemReq=0, out_ChangeAddress=0.
    - A pop in this cycle -> FETCH next cycle.
  - DROP:
    - out_imemReq=1, out_imemAddr=heldAddr (request held stable).
    - On ack: data is discarded, no push -> FETCH.
- Request stability: once out_imemReq is asserted, out_imemAddr and out_imemReq stay stable until ack. This holds in FETCH because the PC is only loaded on ack or redirect.
- inp_imemAck is ignored while out_imemReq=0.
- Queue:
  - 2 entries, FIFO order.
  - out_instrValid = count!=0. Head is driven combinationally from storage.
  - Pop when out_instrValid & inp_decodeReady.
  - Push and pop in the same cycle at count 1 -> count stays 1, order preserved.
  - Push is impossible at count 2.
- Redirect (inp_branchTaken=1, any state except BOOT) has the highest priority:
  - Queue is flushed to count 0, so out_instrValid=0 next cycle. A same-cycle pop is still a legal handshake.
  - out_ChangeAddress=1, next={inp_branchTarget[15:1],1'b0} (target forced even).
  - State transitions:
    - In FETCH without ack -> DROP.
    - In FETCH with ack -> data discarded, FETCH.
    - In DROP without ack -> stay in DROP; PC retargeted to the newest target.
    - In DROP with ack -> FETCH.
    - In STALL -> FETCH.
- out_ChangeAddress is 0 in every case not listed above, so the PC holds.

Test Plan:
1. RESET_ADDR=16'h1040, rstn low 3 cycles then high -> outputs at reset values while low; first cycle after release ChangeAddress=1/next=0x1040; next cycle req=1, imemAddr=0x1040.
2. Zero-wait memory, decodeReady=1, data=addr^16'hA5A5 -> instrPc 0x1040,0x1042,0x1044 on consecutive cycles with matching data; PC advances by 2 each cycle.
3. decodeReady=0 -> two pushes (0x1040, 0x1042), then req=0 and PC held at 0x1044; raise ready -> 0x1040, 0x1042, then 0x1044 delivered in order with no duplicates.
4. Ack delayed 3 cycles on 0x1042; branch to 0x2001 in cycle 1 -> PC loads 0x2000; imemAddr held at 0x1042 until ack; that data is never delivered; next req is at 0x2000.
5. Branch, ack and pop all in the same cycle with count=1 -> next cycle valid=0; the first instruction delivered afterwards has instrPc=target.
6. PC=0xFFFE, ack -> next=0x0000; the following fetch is from 0x0000. Assert rstn low mid-DROP -> immediate return to reset values, then the BOOT sequence.
